// File: rtl/data_memory_ctrl.sv
// Word-addressed single-port data memory with a valid/ready request port, byte enables,
// a 1- or 2-cycle read pipeline, out-of-range detection and a power-on zero-fill.
module data_memory_ctrl #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam int                BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_r;
  logic [IDX_W-1:0]  cnt_r;
  logic              ready_r;
  logic              init_done_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              accept_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [BE_W-1:0]   wr_be_s;
  logic [DATA_W-1:0] wr_data_s;

  logic              s1_valid_r;
  logic              s1_err_r;
  logic [DATA_W-1:0] s1_data_r;

  // Every upper address bit takes part in the range check, not just the index bits.
  assign accept_s   = req_valid & ready_r;
  assign in_range_s = (req_addr < DEPTH_A);
  assign idx_s      = req_addr[IDX_W-1:0];
  assign req_ready  = ready_r;
  assign init_done  = init_done_r;

  // Init/ready sequencer with fill counter; ready and init_done are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      ready_r     <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if ((INIT_ZERO == 0) || (cnt_r == LAST_IDX)) begin
            state_r     <= ST_READY;
            ready_r     <= 1'b1;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + IDX_W'(1);
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
        end
        default: begin
          state_r     <= ST_INIT;
          cnt_r       <= '0;
          ready_r     <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by the zero-fill and accepted in-range writes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_be_s   = req_be;
    wr_data_s = req_wdata;
    case (state_r)
      ST_INIT: begin
        if (INIT_ZERO != 0) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = cnt_r;
          wr_be_s   = '1;
          wr_data_s = '0;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_READY: begin
        if (accept_s && req_we && in_range_s) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Storage array, deliberately left out of reset; byte lanes update independently.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_s[b]) begin
          mem_r[wr_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
      end
    end
  end

  // First read stage samples the array at the accept edge; data and error are zero unless valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_data_r  <= '0;
    end else begin
      s1_valid_r <= accept_s & ~req_we;
      s1_err_r   <= accept_s & ~req_we & ~in_range_s;
      s1_data_r  <= (accept_s && !req_we && in_range_s) ? mem_r[idx_s] : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid_r;
      logic              s2_err_r;
      logic [DATA_W-1:0] s2_data_r;

      // Second read stage, giving two reads in flight at full throughput.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_r <= 1'b0;
          s2_err_r   <= 1'b0;
          s2_data_r  <= '0;
        end else begin
          s2_valid_r <= s1_valid_r;
          s2_err_r   <= s1_err_r;
          s2_data_r  <= s1_data_r;
        end
      end

      assign rsp_valid = s2_valid_r;
      assign rsp_err   = s2_err_r;
      assign rsp_rdata = s2_data_r;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_r;
      assign rsp_err   = s1_err_r;
      assign rsp_rdata = s1_data_r;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: unit 0 is RD_LAT=1 with zero-fill, unit 1 is RD_LAT=2 without fill.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v     [2];
  logic        req_valid_v [2];
  logic        req_ready_v [2];
  logic        req_we_v    [2];
  logic [15:0] req_addr_v  [2];
  logic [15:0] req_wdata_v [2];
  logic [1:0]  req_be_v    [2];
  logic        rsp_valid_v [2];
  logic [15:0] rsp_rdata_v [2];
  logic        rsp_err_v   [2];
  logic        init_done_v [2];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_w [8];

  data_memory_ctrl #(.DATA_W(16), .DEPTH(8), .ADDR_W(16), .RD_LAT(1), .INIT_ZERO(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we_v[0]), .req_addr(req_addr_v[0]), .req_wdata(req_wdata_v[0]), .req_be(req_be_v[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_v[0]), .rsp_err(rsp_err_v[0]),
    .init_done(init_done_v[0])
  );

  data_memory_ctrl #(.DATA_W(16), .DEPTH(8), .ADDR_W(16), .RD_LAT(2), .INIT_ZERO(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we_v[1]), .req_addr(req_addr_v[1]), .req_wdata(req_wdata_v[1]), .req_be(req_be_v[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_v[1]), .rsp_err(rsp_err_v[1]),
    .init_done(init_done_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int u, input logic [15:0] addr, input logic [15:0] data,
                          input logic [1:0] be);
    req_valid_v[u] = 1'b1;
    req_we_v[u]    = 1'b1;
    req_addr_v[u]  = addr;
    req_wdata_v[u] = data;
    req_be_v[u]    = be;
    @(negedge clk);
    req_valid_v[u] = 1'b0;
    req_we_v[u]    = 1'b0;
  endtask

  task automatic do_read(input int u, input string tag, input logic [15:0] addr,
                         input logic [15:0] exp_data, input logic exp_err, input int lat);
    int  k;
    bit  seen;
    req_valid_v[u] = 1'b1;
    req_we_v[u]    = 1'b0;
    req_addr_v[u]  = addr;
    @(negedge clk);
    req_valid_v[u] = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 4) begin
      if (rsp_valid_v[u]) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "_lat"},  32'(k), 32'(lat));
    chk({tag, "_data"}, 32'(rsp_rdata_v[u]), 32'(exp_data));
    chk({tag, "_err"},  32'(rsp_err_v[u]), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rsp_valid_v[u]), 32'd0);
  endtask

  task automatic release_and_wait(input int u, input string tag, input int exp_cycles);
    int rdy_at;
    int done_at;
    int spurious;
    rdy_at   = 0;
    done_at  = 0;
    spurious = 0;
    rst_n_v[u] = 1'b1;
    for (int n = 1; n <= 20 && rdy_at == 0; n++) begin
      @(negedge clk);
      if (rsp_valid_v[u]) spurious++;
      if (init_done_v[u] && done_at == 0) done_at = n;
      if (req_ready_v[u]) rdy_at = n;
    end
    chk({tag, "_ready_cyc"}, 32'(rdy_at), 32'(exp_cycles));
    chk({tag, "_done_cyc"},  32'(done_at), 32'(exp_cycles));
    chk({tag, "_no_rsp"},    32'(spurious), 32'd0);
  endtask

  initial begin
    int late;
    for (int u = 0; u < 2; u++) begin
      rst_n_v[u]     = 1'b0;
      req_valid_v[u] = 1'b0;
      req_we_v[u]    = 1'b0;
      req_addr_v[u]  = 16'h0000;
      req_wdata_v[u] = 16'h0000;
      req_be_v[u]    = 2'b00;
    end
    repeat (3) @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst%0d_ready", u), 32'(req_ready_v[u]), 32'd0);
      chk($sformatf("rst%0d_rsp_valid", u), 32'(rsp_valid_v[u]), 32'd0);
      chk($sformatf("rst%0d_rdata", u), 32'(rsp_rdata_v[u]), 32'd0);
      chk($sformatf("rst%0d_err", u), 32'(rsp_err_v[u]), 32'd0);
      chk($sformatf("rst%0d_init_done", u), 32'(init_done_v[u]), 32'd0);
    end

    // Zero-fill takes DEPTH cycles, then every word reads back as zero.
    release_and_wait(0, "t1_fill", 8);
    for (int i = 0; i < 8; i++) do_read(0, $sformatf("t1_rd%0d", i), 16'(i), 16'h0000, 1'b0, 1);

    do_write(0, 16'h0003, 16'hBEEF, 2'b11);
    do_read(0, "t2_raw", 16'h0003, 16'hBEEF, 1'b0, 1);

    do_write(0, 16'h0003, 16'h1234, 2'b01);
    do_read(0, "t3_be01", 16'h0003, 16'hBE34, 1'b0, 1);
    do_write(0, 16'h0003, 16'hFFFF, 2'b00);
    do_read(0, "t3_be00", 16'h0003, 16'hBE34, 1'b0, 1);

    // Out-of-range writes alias onto nothing, including ones with only a high bit set.
    do_write(0, 16'h0008, 16'hAAAA, 2'b11);
    do_read(0, "t4_alias0", 16'h0000, 16'h0000, 1'b0, 1);
    do_write(0, 16'h8003, 16'h0000, 2'b11);
    do_read(0, "t4_alias3", 16'h0003, 16'hBE34, 1'b0, 1);
    do_read(0, "t4_oor", 16'h0010, 16'h0000, 1'b1, 1);
    do_read(0, "t4_oor_hi", 16'hFFFF, 16'h0000, 1'b1, 1);

    // Unit 1: no fill, ready one cycle after release; then streamed reads at latency 2.
    release_and_wait(1, "t5_nofill", 1);
    for (int i = 0; i < 8; i++) begin
      exp_w[i] = 16'h1000 + 16'(i) * 16'h0111;
      do_write(1, 16'(i), exp_w[i], 2'b11);
    end
    for (int s = 0; s < 12; s++) begin
      if (s < 8) begin
        req_valid_v[1] = 1'b1;
        req_we_v[1]    = 1'b0;
        req_addr_v[1]  = 16'(s);
      end else begin
        req_valid_v[1] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("t5_valid%0d", s), 32'(rsp_valid_v[1]), (s >= 1 && s <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("t5_data%0d", s), 32'(rsp_rdata_v[1]),
          (s >= 1 && s <= 8) ? 32'(exp_w[s-1]) : 32'd0);
    end

    // Reset with a response on the wire: it must vanish at once and the fill must restart.
    do_write(0, 16'h0001, 16'h5555, 2'b11);
    req_valid_v[0] = 1'b1;
    req_we_v[0]    = 1'b0;
    req_addr_v[0]  = 16'h0001;
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    chk("t6a_rsp_before_rst", 32'(rsp_valid_v[0]), 32'd1);
    rst_n_v[0] = 1'b0;
    #1;
    chk("t6a_rsp_dropped", 32'(rsp_valid_v[0]), 32'd0);
    chk("t6a_rdata_zero", 32'(rsp_rdata_v[0]), 32'd0);
    chk("t6a_ready_dropped", 32'(req_ready_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    release_and_wait(0, "t6a_refill", 8);
    do_read(0, "t6a_cleared", 16'h0001, 16'h0000, 1'b0, 1);

    // Same on unit 1 with the read still in the first pipeline stage; contents survive.
    do_write(1, 16'h0001, 16'h5555, 2'b11);
    req_valid_v[1] = 1'b1;
    req_we_v[1]    = 1'b0;
    req_addr_v[1]  = 16'h0001;
    @(negedge clk);
    req_valid_v[1] = 1'b0;
    rst_n_v[1] = 1'b0;
    #1;
    chk("t6b_rsp_low", 32'(rsp_valid_v[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    release_and_wait(1, "t6b_restart", 1);
    late = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid_v[1]) late++;
    end
    chk("t6b_no_late_rsp", 32'(late), 32'd0);
    do_read(1, "t6b_kept", 16'h0001, 16'h5555, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, word-addressed, single-port synchronous data memory for the processor datapath.
- Adds features the original data memory lacks:
  - valid/ready request handshake
  - per-byte write enables
  - configurable read latency
  - out-of-range address detection
  - power-on zero-fill sequencer
- Sits between the execute/memory stage and the register-file write-back path.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; power of two, at least 2.
- ADDR_W, 16, width of the incoming address bus.
- RD_LAT, 1, read latency in cycles from accept to response; legal values 1 or 2.
- INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip fill.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit i enables byte i of the word
- rsp_valid  out  1  read response valid, one-cycle pulse per read
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response is for an out-of-range read
- init_done  out  1  zero-fill complete; stays high until next reset

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- IDX_W = clog2(DEPTH). Word index = req_addr[IDX_W-1:0].
- An address is in range when req_addr < DEPTH. All upper address bits are checked.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, read pipeline empty, fill counter=0.
- The storage array itself is not reset by rst_n.
- State machine: INIT, READY.
  - rst_n low forces INIT asynchronously.
  - INIT, INIT_ZERO=1: each cycle write 0 to word[cnt] and increment cnt. On the cycle cnt==DEPTH-1 is written, go to READY.
  - INIT, INIT_ZERO=0: go to READY on the first clock after reset release.
  - Fill length is DEPTH cycles when enabled.
  - init_done and req_ready go high on entry to READY.
  - READY: stay until reset.
- req_ready = (state==READY). It does not depend on req_valid.
- Accept: req_valid & req_ready at a rising edge. One request per cycle, no bubbles required.
- Write accept, in range: each byte i with req_be[i]=1 is updated at that edge; other bytes are kept. be=0 is a legal no-op. Writes produce no response.
- Write accept, out of range: dropped and the array is unchanged. No response, no error signal.
- Read accept:
  - Array sampled at the accept edge.
  - rsp_valid is high exactly RD_LAT cycles after the accept edge, for one cycle.
  - In range: rsp_rdata = stored word, rsp_err=0.
  - Out of range: rsp_rdata=0, rsp_err=1.
- Responses return in request order. No response backpressure; the consumer must take every response.
- When rsp_valid=0: rsp_rdata=0 and rsp_err=0.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the new data. Single port, so no same-cycle conflict is possible.
- Back-to-back reads: full throughput. With RD_LAT=2, two reads are in flight.
- Reset mid-operation:
  - In-flight reads are discarded and rsp_valid drops immediately.
  - No response is produced after release.
  - With INIT_ZERO=1, the fill restarts at word 0.
- req_wdata, req_be and req_addr are ignored when no accept occurs.

Test Plan:
1. Defaults, release rst_n → req_ready and init_done stay 0 for exactly 8 clock edges, then go 1 together. Reading words 0..7 all return 0x0000.
2. Write 0xBEEF to addr 3 with be=2'b11. Next cycle read addr 3 → rsp_valid one cycle after the read accept, rsp_rdata=0xBEEF, rsp_err=0.
3. Write 0x1234 to addr 3 with be=2'b01, then read addr 3 → 0xBE34. Write with be=2'b00, then read → still 0xBE34.
4. Write 0xAAAA to addr 0x0008 → read addr 0 returns 0x0000. Read addr 0x0010 → rsp_valid=1, rsp_err=1, rsp_rdata=0x0000.
5. RD_LAT=2, req_valid held high reading addrs 0..7 on consecutive cycles → 8 consecutive rsp_valid cycles, first one 2 cycles after the first accept, data in order.
6. Write 0x5555 to addr 1, then issue a read; pull rst_n low one cycle after that accept → rsp_valid 0 immediately and no response after release. After 8 fill cycles, addr 1 reads 0x0000. Repeat with INIT_ZERO=0 → ready 1 cycle after release and addr 1 reads 0x5555.
